// File: rtl/bloom_frame_sched.sv
// bloom_frame_sched: frame scheduler for a pool of blooming cores.
// Takes host frame requests and dispatches each one round-robin to an idle core.
// Each running core has a cycle counter and a watchdog. When a core ends or
// times out, one completion record is returned through a valid/ready output
// register.
module bloom_frame_sched #(
  parameter int unsigned CORE_NUM       = 4,
  parameter int unsigned CORE_IDX_WIDTH = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT        = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  output logic [CORE_NUM-1:0]       core_start,
  input  logic [CORE_NUM-1:0]       core_end,
  output logic [CORE_NUM-1:0]       busy,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [CORE_IDX_WIDTH-1:0] done_core,
  output logic [CNT_WIDTH-1:0]      done_cycles,
  output logic                      done_timeout,
  output logic [CNT_WIDTH-1:0]      frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } core_st_e;

  core_st_e                  state_q      [CORE_NUM];
  logic [CNT_WIDTH-1:0]      cnt_q        [CORE_NUM];
  logic [CNT_WIDTH-1:0]      cap_cycles_q [CORE_NUM];
  logic                      cap_to_q     [CORE_NUM];

  logic [CORE_NUM-1:0]       start_q, start_d;
  logic [CORE_IDX_WIDTH-1:0] disp_ptr_q, disp_ptr_d;
  logic [CORE_IDX_WIDTH-1:0] rep_ptr_q, rep_ptr_d;
  logic [CNT_WIDTH-1:0]      frame_cnt_q;
  logic                      done_valid_q;
  logic [CORE_IDX_WIDTH-1:0] done_core_q;
  logic [CNT_WIDTH-1:0]      done_cycles_q;
  logic                      done_timeout_q;

  logic [CORE_NUM-1:0]       idle_vec, report_vec;
  logic                      grant_found, rep_found;
  logic [CORE_IDX_WIDTH-1:0] grant_idx, rep_idx, cand;
  logic                      accept, load_en;

  localparam logic [CNT_WIDTH-1:0]      TO_VAL   = CNT_WIDTH'(TIMEOUT);
  localparam logic [CORE_IDX_WIDTH-1:0] LAST_IDX = CORE_IDX_WIDTH'(CORE_NUM - 1);

  // Decode per-core state into idle / report / busy vectors
  always_comb begin
    idle_vec   = '0;
    report_vec = '0;
    for (int unsigned k = 0; k < CORE_NUM; k++) begin
      idle_vec[k]   = (state_q[k] == ST_IDLE);
      report_vec[k] = (state_q[k] == ST_REPORT);
    end
  end

  assign busy        = ~idle_vec;
  assign frame_ready = |idle_vec;
  assign accept      = frame_valid & frame_ready;
  assign load_en     = ~done_valid_q | done_ready;

  // Round-robin searches: first idle core and first reporting core, each at or after its pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rep_found   = 1'b0;
    rep_idx     = '0;
    cand        = '0;
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      cand = CORE_IDX_WIDTH'((32'(disp_ptr_q) + i) % CORE_NUM);
      if (!grant_found && idle_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = CORE_IDX_WIDTH'((32'(rep_ptr_q) + i) % CORE_NUM);
      if (!rep_found && report_vec[cand]) begin
        rep_found = 1'b1;
        rep_idx   = cand;
      end
    end
  end

  // Next start pulse vector and pointer advances
  always_comb begin
    start_d = '0;
    for (int unsigned k = 0; k < CORE_NUM; k++) begin
      start_d[k] = accept && (grant_idx == CORE_IDX_WIDTH'(k));
    end
    disp_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    rep_ptr_d  = (rep_idx == LAST_IDX) ? '0 : rep_idx + 1'b1;
  end

  // Per-core FSM: IDLE -> RUN on dispatch, RUN -> REPORT on end/timeout, REPORT -> IDLE when unloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CORE_NUM; k++) begin
        state_q[k]      <= ST_IDLE;
        cnt_q[k]        <= '0;
        cap_cycles_q[k] <= '0;
        cap_to_q[k]     <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < CORE_NUM; k++) begin
        case (state_q[k])
          ST_IDLE: begin
            if (start_d[k]) begin
              state_q[k] <= ST_RUN;
              cnt_q[k]   <= '0;
            end
          end
          ST_RUN: begin
            // an end pulse takes priority over a watchdog expiry in the same cycle
            if (core_end[k]) begin
              state_q[k]      <= ST_REPORT;
              cap_cycles_q[k] <= cnt_q[k];
              cap_to_q[k]     <= 1'b0;
            end else if (cnt_q[k] == TO_VAL) begin
              state_q[k]      <= ST_REPORT;
              cap_cycles_q[k] <= TO_VAL;
              cap_to_q[k]     <= 1'b1;
            end else begin
              cnt_q[k] <= cnt_q[k] + 1'b1;
            end
          end
          ST_REPORT: begin
            if (load_en && rep_found && (rep_idx == CORE_IDX_WIDTH'(k))) begin
              state_q[k] <= ST_IDLE;
            end
          end
          default: state_q[k] <= ST_IDLE;
        endcase
      end
    end
  end

  // Dispatch side: start pulse, dispatch pointer, accepted-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= '0;
      disp_ptr_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      start_q <= start_d;
      if (accept) begin
        disp_ptr_q  <= disp_ptr_d;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Completion output register: reload whenever empty or being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid_q   <= 1'b0;
      done_core_q    <= '0;
      done_cycles_q  <= '0;
      done_timeout_q <= 1'b0;
      rep_ptr_q      <= '0;
    end else if (load_en) begin
      if (rep_found) begin
        done_valid_q   <= 1'b1;
        done_core_q    <= rep_idx;
        done_cycles_q  <= cap_cycles_q[rep_idx];
        done_timeout_q <= cap_to_q[rep_idx];
        rep_ptr_q      <= rep_ptr_d;
      end else begin
        done_valid_q <= 1'b0;
      end
    end
  end

  assign core_start   = start_q;
  assign frame_cnt    = frame_cnt_q;
  assign done_valid   = done_valid_q;
  assign done_core    = done_core_q;
  assign done_cycles  = done_cycles_q;
  assign done_timeout = done_timeout_q;

endmodule
